// File: rtl/keypad_pkg.sv
// Shared types and key decode for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_e;

    localparam logic [3:0] COL_IDLE = 4'hF;
    localparam logic [1:0] ROW_FIRST = 2'd0;

    // Indexed [row][col]; row 0 is the top row of the pad.
    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [3:0] key_decode(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        return KEY_MAP[row_idx][col_idx];
    endfunction

    function automatic logic [1:0] low_col_idx(input logic [3:0] col_pat);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_pat[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
        return ~(4'b0001 << row_idx);
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// Free-running scan-tick divider: one-cycle tick every SCAN_DIV clocks.
module keypad_tick #(
    parameter int SCAN_DIV = 48000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounced press/release and a one-clk key strobe.
// Define KEYPAD_REPEAT_EN to re-strobe the held key every REPEAT_TICKS scan ticks.
//
// state         | meaning
// ST_SCAN       | rotate the low row each tick until some column reads low
// ST_PRESS_DB   | row frozen, waiting for the captured column pattern to stay stable
// ST_HELD       | key accepted and strobed, row frozen until all columns read high
// ST_RELEASE_DB | waiting for all columns to stay high before scanning resumes
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 48000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_scanner: SCAN_DIV must be >= 2 and tick counts >= 1");
    end

    logic       tick;
    state_e     state_q,     state_d;
    logic [1:0] row_idx_q,   row_idx_d;
    logic [3:0] cap_q,       cap_d;
    logic [DB_W-1:0] cnt_q,  cnt_d;
    logic [3:0] key_q,       key_d;
    logic       key_valid_q, key_valid_d;
    logic [3:0] col_s1_q,    col_s1_d;
    logic [3:0] col_s2_q,    col_s2_d;
    logic [3:0] col_sync;
    logic       cols_idle;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    keypad_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign col_sync  = col_s2_q;
    assign cols_idle = (col_sync == COL_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            row_idx_q   <= ROW_FIRST;
            cap_q       <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            col_s1_q    <= '0;
            col_s2_q    <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            col_s1_q    <= col_s1_d;
            col_s2_q    <= col_s2_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        col_s1_d    = col;
        col_s2_d    = col_s1_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (cols_idle) begin
                        row_idx_d = row_idx_q + 2'd1;
                    end else begin
                        cap_d   = col_sync;
                        cnt_d   = '0;
                        state_d = ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    // The whole pattern must hold, not just the decoded column.
                    if (col_sync != cap_q) begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end else if (cnt_q == DB_LAST) begin
                        key_d       = key_decode(row_idx_q, low_col_idx(cap_q));
                        key_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_d       = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (cols_idle) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE_DB;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q == REP_LAST) begin
                        rep_d       = '0;
                        key_valid_d = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
                ST_RELEASE_DB: begin
                    if (!cols_idle) begin
                        cnt_d = '0;
                    end else if (cnt_q == DB_LAST) begin
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    always_comb begin
        row       = row_drive(row_idx_q);
        key       = key_q;
        key_valid = key_valid_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a tick-level keypad model checked every cycle.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int REPEAT_TICKS   = 5;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_REPEAT_STROBES = 4;
`else
    localparam int EXP_REPEAT_STROBES = 1;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        key_valid;
    logic [15:0] press_map = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int kv_cnt   = 0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .REPEAT_TICKS   (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (press_map[r*4+c]) col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Keypad behaviour model: phase 0 scanning, 1 confirming press, 2 held, 3 confirming release.
    int         m_cyc, m_phase, m_row, m_run, m_rep, m_key;
    logic [3:0] m_h1, m_h2, m_cap;
    logic       m_kv;
    logic       prev_kv = 1'b0;
    int key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    function automatic int lowest_low(input logic [3:0] p);
        for (int c = 0; c < 4; c++) if (!p[c]) return c;
        return 0;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_phase = 0; m_row = 0; m_run = 0; m_rep = 0; m_key = 0;
        m_h1 = 4'h0; m_h2 = 4'h0; m_cap = 4'h0; m_kv = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] col_now);
        logic [3:0] seen;
        bit         is_tick;
        seen    = m_h2;
        m_h2    = m_h1;
        m_h1    = col_now;
        is_tick = (m_cyc % SCAN_DIV) == (SCAN_DIV - 1);
        m_cyc++;
        m_kv = 1'b0;
        if (is_tick) begin
            case (m_phase)
                0: if (seen == 4'hF) m_row = (m_row + 1) % 4;
                   else begin m_cap = seen; m_run = 0; m_phase = 1; end
                1: if (seen != m_cap) begin m_run = 0; m_phase = 0; end
                   else begin
                       m_run++;
                       if (m_run == DEBOUNCE_TICKS) begin
                           m_key = key_map[m_row*4 + lowest_low(m_cap)];
                           m_kv = 1'b1; m_phase = 2; m_run = 0; m_rep = 0;
                       end
                   end
                2: if (seen == 4'hF) begin m_phase = 3; m_run = 0; end
`ifdef KEYPAD_REPEAT_EN
                   else begin
                       m_rep++;
                       if (m_rep == REPEAT_TICKS) begin m_rep = 0; m_kv = 1'b1; end
                   end
`endif
                default: if (seen != 4'hF) m_run = 0;
                   else begin
                       m_run++;
                       if (m_run == DEBOUNCE_TICKS) begin
                           m_run = 0; m_phase = 0; m_row = (m_row + 1) % 4;
                       end
                   end
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            logic [3:0] exp_row;
            @(negedge clk);
            if (!rst_n) model_reset();
            exp_row = 4'hF;
            exp_row[m_row] = 1'b0;
            check("row", row, exp_row);
            check("key", key, m_key);
            check("key_valid", key_valid, m_kv);
            if (key_valid) begin
                check("key_valid_back_to_back", prev_kv, 1'b0);
                kv_cnt++;
            end
            prev_kv = key_valid;
            if (rst_n) model_step(col);
        end
    end

    task automatic set_keys(input logic [15:0] m);
        @(posedge clk); #2; press_map = m;
    endtask

    task automatic set_reset(input logic v);
        @(posedge clk); #2; rst_n = v;
    endtask

    task automatic wait_phase(input int ph, input int budget, input string name);
        int k;
        k = 0;
        while (m_phase != ph && k < budget) begin
            @(negedge clk); #1; k++;
        end
        n_checks++;
        if (m_phase != ph) begin
            n_fail++;
            $display("FAIL %s: timeout, phase %0d, expected %0d", name, m_phase, ph);
        end
    endtask

    task automatic wait_strobe(input int budget, input string name);
        int k;
        k = 0;
        while (!key_valid && k < budget) begin
            @(negedge clk); #1; k++;
        end
        n_checks++;
        if (!key_valid) begin
            n_fail++;
            $display("FAIL %s: timeout, key_valid=%0b, expected 1", name, key_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        set_reset(1'b1);

        // idle scanning
        base = kv_cnt;
        @(negedge clk);
        check("reset_row", row, 4'b1110);
        check("reset_key", key, 4'h0);
        repeat (5) @(negedge clk);
        check("idle_row_after_first_tick", row, 4'b1101);
        repeat (12) @(negedge clk);
        check("idle_row_wrapped", row, 4'b1110);
        check("idle_no_strobe", kv_cnt - base, 0);

        // one-tick bounce on r0c0
        base = kv_cnt;
        set_keys(16'h0001);
        wait_phase(1, 60, "bounce_capture");
        set_keys(16'h0000);
        wait_phase(0, 60, "bounce_abort");
        repeat (8) @(posedge clk);
        check("bounce_no_strobe", kv_cnt - base, 0);

        // r1c2 stable press with a bounce during release
        base = kv_cnt;
        set_keys(16'h0040);
        wait_strobe(200, "r1c2_strobe");
        check("r1c2_key", key, 4'h6);
        check("r1c2_row_frozen", row, 4'b1101);
        repeat (12) @(posedge clk);
        set_keys(16'h0000);
        wait_phase(3, 60, "r1c2_release_start");
        repeat (5) @(posedge clk);
        set_keys(16'h0040);
        repeat (8) @(posedge clk);
        check("r1c2_row_during_release_bounce", row, 4'b1101);
        set_keys(16'h0000);
        wait_phase(0, 100, "r1c2_release_done");
        check("r1c2_single_strobe", kv_cnt - base, 1);

        // r3c1 + r3c3 together, then r0c0 while held
        base = kv_cnt;
        set_keys(16'hA000);
        wait_strobe(200, "combo_strobe");
        check("combo_key_lowest_col", key, 4'h0);
        set_keys(16'hA001);
        repeat (20) @(posedge clk);
        check("combo_second_key_ignored", kv_cnt - base, 1);
        set_keys(16'h0000);
        wait_phase(0, 100, "combo_release_done");
        check("combo_strobes", kv_cnt - base, 1);

        // long hold of r2c3
        base = kv_cnt;
        set_keys(16'h0800);
        wait_strobe(200, "hold_strobe");
        check("hold_key", key, 4'hC);
        repeat (70) @(posedge clk);
        set_keys(16'h0000);
        wait_phase(0, 100, "hold_release_done");
        check("hold_strobe_count", kv_cnt - base, EXP_REPEAT_STROBES);
        check("hold_key_unchanged", key, 4'hC);

        // reset in the middle of press debounce
        base = kv_cnt;
        set_keys(16'h0800);
        wait_phase(1, 60, "reset_press_capture");
        repeat (4) @(posedge clk);
        set_reset(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mid_row", row, 4'b1110);
        check("reset_mid_key", key, 4'h0);
        check("reset_mid_key_valid", key_valid, 1'b0);
        set_keys(16'h0000);
        set_reset(1'b1);
        @(negedge clk);
        check("reset_release_row", row, 4'b1110);
        repeat (24) @(posedge clk);
        check("reset_no_strobe", kv_cnt - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
